// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Arbitrates register-file writes between two requesters. Requester A is the
// ALU writeback and requester B is the memory-load writeback. When both
// requesters are pending, the grant alternates between them (round-robin).
// A CLR_START pulse runs a zero-fill sequence that writes 0 to every
// register, one register per cycle.
//
// Parameters
//   DATA_WIDTH  width of the register-file write data
//   ADDR_WIDTH  width of the register-file address (2**ADDR_WIDTH registers)
//
// Ports
//   CLK        clock; all state updates on the rising edge
//   RESET      asynchronous, active-high reset
//   A_VALID    requester A has a write pending
//   A_ADDR     requester A destination register
//   A_DATA     requester A write data
//   A_READY    requester A write accepted this cycle (combinational)
//   B_VALID    requester B has a write pending
//   B_ADDR     requester B destination register
//   B_DATA     requester B write data
//   B_READY    requester B write accepted this cycle (combinational)
//   CLR_START  single-cycle pulse requesting a zero-fill of all registers
//   CLR_BUSY   zero-fill sequence in progress (registered)
//   WRITE      register-file write enable (registered)
//   INADDRESS  register-file write address (registered)
//   IN         register-file write data (registered)
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  A_VALID,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    output logic                  A_READY,
    input  logic                  B_VALID,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    output logic                  B_READY,
    input  logic                  CLR_START,
    output logic                  CLR_BUSY,
    output logic                  WRITE,
    output logic [ADDR_WIDTH-1:0] INADDRESS,
    output logic [DATA_WIDTH-1:0] IN
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_q;
    // 0: A is favoured on contention, 1: B is favoured.
    logic                    prio_b_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    busy_q;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;

    // Grants are combinational so a requester sees acceptance in the same
    // cycle it presents VALID. RESET and CLR_START both suppress grants, and
    // no grant is ever given while the zero-fill is running.
    always_comb begin
        A_READY = 1'b0;
        B_READY = 1'b0;
        if (!RESET && (state_q == ARB) && !CLR_START) begin
            if (A_VALID && (!B_VALID || !prio_b_q)) begin
                A_READY = 1'b1;
            end else if (B_VALID) begin
                B_READY = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ARB;
            prio_b_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    // Address/data hold their last value when idle; only the
                    // enable drops.
                    write_q <= 1'b0;
                    if (CLR_START) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else if (A_READY) begin
                        write_q  <= 1'b1;
                        addr_q   <= A_ADDR;
                        data_q   <= A_DATA;
                        prio_b_q <= 1'b1;
                    end else if (B_READY) begin
                        write_q  <= 1'b1;
                        addr_q   <= B_ADDR;
                        data_q   <= B_DATA;
                        prio_b_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    // CLR_START is not looked at here, so a repeated pulse can
                    // neither restart nor lengthen the sequence. The counter
                    // wraps to 0 on the final increment.
                    write_q <= 1'b1;
                    addr_q  <= cnt_q;
                    data_q  <= '0;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= ARB;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign CLR_BUSY  = busy_q;
    assign WRITE     = write_q;
    assign INADDRESS = addr_q;
    assign IN        = data_q;

endmodule
